// File: rtl/ifetch.sv
// ifetch: instruction fetch unit, the requester side of a synchronous-read
// instruction ROM (one-cycle read latency).
//
// It owns the PC, issues word fetches and pairs each returned word with its PC.
// It presents the result to decode over a valid/stall handshake. A redirect
// reloads the PC and kills both the in-flight read and the presented
// instruction. While decode stalls, a one-entry hold buffer keeps the
// presented word stable.
//
// Optional feature: define IF_PERF_CNT_EN to add the fetch_cnt port. It is a
// 32-bit count of instructions accepted by decode.
//
// Ports:
//   clk          core clock; the ROM samples im_addr on the same edge
//   rst_n        asynchronous active-low reset
//   im_addr      registered fetch address (the ROM uses [11:2])
//   im_dout      ROM data for the address sampled at the previous edge
//   redirect     load redirect_pc and kill in-flight/presented work
//   redirect_pc  redirect target; bits [1:0] are ignored
//   stall        decode cannot accept the presented instruction
//   if_valid     if_pc/if_instr hold a live instruction
//   if_pc        PC of the presented instruction
//   if_instr     presented instruction, 0 when not valid
//   fetch_cnt    accepted-instruction count (IF_PERF_CNT_EN only)
module ifetch #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
   input  logic        clk,
   input  logic        rst_n,
   output logic [31:0] im_addr,
   input  logic [0:31] im_dout,
   input  logic        redirect,
   input  logic [31:0] redirect_pc,
   input  logic        stall,
   output logic        if_valid,
   output logic [31:0] if_pc,
   output logic [0:31] if_instr
`ifdef IF_PERF_CNT_EN
   ,
   output logic [31:0] fetch_cnt
`endif
);

   logic [31:0] pc_q, pc_d;
   logic        rsp_valid_q, rsp_valid_d;
   logic [31:0] rsp_pc_q, rsp_pc_d;
   logic        hold_valid_q, hold_valid_d;
   logic [0:31] hold_instr_q, hold_instr_d;

   always_comb begin
      pc_d         = pc_q;
      rsp_valid_d  = rsp_valid_q;
      rsp_pc_d     = rsp_pc_q;
      hold_valid_d = hold_valid_q;
      hold_instr_d = hold_instr_q;
      if (redirect) begin
         // The read issued on this edge is dropped via rsp_valid_d = 0.
         pc_d         = redirect_pc & 32'hFFFF_FFFC;
         rsp_valid_d  = 1'b0;
         hold_valid_d = 1'b0;
      end else if (stall && rsp_valid_q) begin
         // The ROM re-reads pc_q, so im_dout holds the next word by the time
         // the stall releases. Only the presented word needs buffering.
         if (!hold_valid_q) begin
            hold_instr_d = im_dout;
            hold_valid_d = 1'b1;
         end
      end else begin
         rsp_pc_d     = pc_q;
         rsp_valid_d  = 1'b1;
         pc_d         = pc_q + 32'd4;
         hold_valid_d = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pc_q         <= RESET_PC;
         rsp_valid_q  <= 1'b0;
         rsp_pc_q     <= 32'd0;
         hold_valid_q <= 1'b0;
         hold_instr_q <= 32'd0;
      end else begin
         pc_q         <= pc_d;
         rsp_valid_q  <= rsp_valid_d;
         rsp_pc_q     <= rsp_pc_d;
         hold_valid_q <= hold_valid_d;
         hold_instr_q <= hold_instr_d;
      end
   end

   always_comb begin
      im_addr  = pc_q;
      if_valid = rsp_valid_q;
      if_pc    = rsp_pc_q;
      if_instr = 32'd0;
      if (rsp_valid_q) begin
         if_instr = hold_valid_q ? hold_instr_q : im_dout;
      end
   end

`ifdef IF_PERF_CNT_EN
   logic        accept;
   logic [31:0] cnt_q;

   // A redirect kills the presented instruction, so it is never counted.
   assign accept = rsp_valid_q & ~stall & ~redirect;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q <= 32'd0;
      end else if (accept) begin
         cnt_q <= cnt_q + 32'd1;
      end
   end

   assign fetch_cnt = cnt_q;
`endif

endmodule

// File: doc/ifetch.md
# ifetch

Instruction fetch unit for the PPC core: the requester side of the instruction memory. It owns the program counter, drives the word address into the synchronous-read instruction ROM (one-cycle read latency), pairs each returned instruction word with its PC, and presents it to decode through a valid/stall handshake. It supports branch/exception redirect and holds the current instruction while decode stalls.

## Interface
- `RESET_PC`, default `32'h0000_0000`: PC presented to IM out of reset (IM base address).
- `clk`  in  1  core clock; IM samples `im_addr` on the same rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `im_addr`  out  `[31:0]`  fetch address to IM, registered; IM uses `[11:2]`.
- `im_dout`  in  `[0:31]`  IM read data for the address sampled at the previous edge; bit 0 is MSB.
- `redirect`  in  1  load a new PC and kill in-flight and presented instructions.
- `redirect_pc`  in  `[31:0]`  target PC; bits `[1:0]` are forced to 0.
- `stall`  in  1  decode cannot accept the presented instruction this cycle.
- `if_valid`  out  1  `if_pc`/`if_instr` hold a live instruction.
- `if_pc`  out  `[31:0]`  PC of the presented instruction.
- `if_instr`  out  `[0:31]`  presented instruction; 0 when `if_valid`=0.
- `fetch_cnt`  out  `[31:0]`  accepted-instruction count (only with `IF_PERF_CNT_EN`).

## Operation
- Registers:
  - `pc_q`: drives `im_addr`.
  - `rsp_valid_q`, `rsp_pc_q`: response currently on `im_dout`.
  - `hold_valid_q`, `hold_instr_q`: stall buffer.
- Outputs:
  - `if_valid` = `rsp_valid_q`.
  - `if_pc` = `rsp_pc_q`.
  - `if_instr` = `hold_valid_q ? hold_instr_q : im_dout`, gated to 0 when not valid.
- Accept = `if_valid & ~stall & ~redirect`. When `redirect`=1 the presented instruction is killed; decode must ignore it.
- Per-edge priority:
  - **Redirect** (highest): `pc_q <= {redirect_pc[31:2],2'b00}`, `rsp_valid_q <= 0`, `hold_valid_q <= 0`. The IM read issued on this edge is discarded.
  - **Stall with `if_valid`=1**: `pc_q`, `rsp_pc_q` and `rsp_valid_q` hold. If `hold_valid_q`=0, capture `im_dout` into `hold_instr_q` and set `hold_valid_q`. IM re-reads `pc_q`, so data is correct again when the stall ends.
  - **Otherwise (advance)**: `rsp_pc_q <= pc_q`, `rsp_valid_q <= 1`, `pc_q <= pc_q + 4`, `hold_valid_q <= 0`.
- Arithmetic: PC increment is 32-bit modulo 2^32; `32'hFFFF_FFFC + 4` wraps to 0. IM index wrap at 1024 words is inherent. `stall` while `if_valid`=0 is ignored; fetch advances.
- Reset (asynchronous):
  - `pc_q` = `RESET_PC`; `rsp_valid_q`, `hold_valid_q`, `rsp_pc_q`, `hold_instr_q`, `fetch_cnt` = 0.
  - Outputs during reset: `im_addr`=`RESET_PC`, `if_valid`=0, `if_pc`=0, `if_instr`=0.
  - Reset asserted mid-stall or mid-redirect discards all state immediately.

## Timing
- First edge after `rst_n` rises: IM samples `RESET_PC`. In the following cycle `if_valid`=1, `if_pc`=`RESET_PC`.
- Steady state without stalls: one instruction per cycle; `im_addr` leads `if_pc` by 4.
- Redirect asserted at edge k: cycle k+1 has `if_valid`=0 and `im_addr`=target. Cycle k+2 presents the target instruction. Bubble is exactly 1 cycle.
- Stall: outputs are stable for every stalled cycle. The instruction is accepted on the first edge with `stall`=0. The next instruction is valid in the following cycle with no bubble.
- No combinational path from `stall` or `redirect` to `im_addr`. `if_instr` is combinational from `im_dout`.

## Configuration
- `IF_PERF_CNT_EN` defined: adds port `fetch_cnt`, a 32-bit counter.
  - Increments by 1 on each accept edge.
  - Wraps at 2^32.
  - Reset to 0.
  - Unaffected by a redirect edge, except that the killed instruction is not counted.
- `IF_PERF_CNT_EN` undefined: port and counter are absent; the rest of the behaviour is identical.

## Test plan
- **Reset release**, `RESET_PC`=0, ROM word n = n: `if_pc` sequence 0,4,8,… with `if_instr` = 0,1,2,… one per cycle; `if_valid`=0 until the first post-reset edge completes.
- **Stall for 3 cycles** while `if_pc`=`0x10`: `if_pc`=`0x10` and `if_instr`=4 are held for all 3 cycles. After the stall, `0x14`/5 appears with no gap and no skipped or duplicated word.
- **Redirect to `0x200`** while `if_pc`=`0x8`: next cycle `if_valid`=0. The cycle after presents `if_pc`=`0x200`, `if_instr`=`0x80`. `fetch_cnt` does not count the `0x8` instruction.
- **Redirect and stall in the same cycle**, plus redirect to `0x203`: redirect wins, the hold buffer is cleared, and the target fetched is `0x200`.
- **Wrap**: `redirect_pc`=`0xFFFF_FFFC`, then free-run: `if_pc` goes `0xFFFF_FFFC` → `0x0000_0000`.
- **Async reset** asserted mid-stall with `hold_valid`=1: `if_valid`=0 and `im_addr`=`RESET_PC` immediately, without waiting for a clock edge. `fetch_cnt`=0 when `IF_PERF_CNT_EN` is defined.
